// File: rtl/mips_pc_pkg.sv
// Shared constants and FSM state type for the delay-slot PC sequencer.
package mips_pc_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational transfer-target selection: jump_reg > jump_imm > branch_cond.
module pc_target_calc
  import mips_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_cond,
  input  logic        jump_imm,
  input  logic        jump_reg,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_plus4,
  output logic        any_req,
  output logic        reg_misaligned,
  output logic [31:0] target
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  // Word offset sign-extended and scaled; the add wraps modulo 2^32.
  assign branch_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  assign any_req        = jump_reg | jump_imm | branch_cond;
  assign reg_misaligned = jump_reg & (reg_target[1:0] != 2'b00);

  always_comb begin
    target = branch_target;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump_imm) begin
      target = jump_target;
    end
  end

endmodule

// File: rtl/pc_delay_sequencer.sv
// MIPS-style PC sequencer with one architectural delay slot and a halt address.
module pc_delay_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        branch_cond,
  input  logic        jump_imm,
  input  logic        jump_reg,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_fault,
  output pc_state_e   state_dbg
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_target_q, held_target_d;
  logic        addr_fault_q, addr_fault_d;

  logic [31:0] pc_plus4;
  logic        any_req;
  logic        reg_misaligned;
  logic [31:0] target;

  pc_target_calc u_target_calc (
    .pc            (pc_q),
    .branch_cond   (branch_cond),
    .jump_imm      (jump_imm),
    .jump_reg      (jump_reg),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .pc_plus4      (pc_plus4),
    .any_req       (any_req),
    .reg_misaligned(reg_misaligned),
    .target        (target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NORMAL;
      pc_q          <= RESET_VECTOR;
      held_target_q <= 32'd0;
      addr_fault_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      held_target_q <= held_target_d;
      addr_fault_q  <= addr_fault_d;
    end
  end

  // Requests are sampled only in NORMAL on an enabled cycle; anywhere else they are dropped.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    held_target_d = held_target_q;
    addr_fault_d  = addr_fault_q;
    if (clk_enable) begin
      case (state_q)
        NORMAL: begin
          pc_d = pc_plus4;
          if (any_req) begin
            held_target_d = target;
            state_d       = DELAY;
            if (reg_misaligned) begin
              addr_fault_d = 1'b1;
            end
          end
        end
        DELAY: begin
          pc_d    = held_target_q;
          state_d = (held_target_q == HALT_ADDR) ? HALTED : NORMAL;
        end
        HALTED: begin
          pc_d    = HALT_ADDR;
          state_d = HALTED;
        end
        default: begin
          state_d = NORMAL;
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign pc_plus8      = pc_q + 32'd8;
  assign in_delay_slot = (state_q == DELAY);
  assign active        = (state_q != HALTED);
  assign addr_fault    = addr_fault_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pc_delay_sequencer.sv
// Directed bench for pc_delay_sequencer: vector table plus stall/reset sequences.
module tb_pc_delay_sequencer;
  import mips_pc_pkg::*;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        branch_cond;
  logic        jump_imm;
  logic        jump_reg;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        in_delay_slot;
  logic        active;
  logic        addr_fault;
  pc_state_e   state_dbg;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        en;
    logic        bc;
    logic        ji;
    logic        jr;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rt;
    logic [31:0] exp_pc;
    logic        exp_ds;
    logic        exp_act;
    logic        exp_flt;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pc_delay_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .branch_cond  (branch_cond),
    .jump_imm     (jump_imm),
    .jump_reg     (jump_reg),
    .branch_offset(branch_offset),
    .jump_index   (jump_index),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_plus8     (pc_plus8),
    .in_delay_slot(in_delay_slot),
    .active       (active),
    .addr_fault   (addr_fault),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors = errors + 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic bc, input logic ji,
                     input logic jr, input logic [15:0] off, input logic [25:0] idx,
                     input logic [31:0] rt, input logic [31:0] epc, input logic eds,
                     input logic eact, input logic eflt, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.bc = bc; v.ji = ji; v.jr = jr;
    v.off = off; v.idx = idx; v.rt = rt;
    v.exp_pc = epc; v.exp_ds = eds; v.exp_act = eact; v.exp_flt = eflt;
    v.name = name;
    vecs.push_back(v);
  endtask

  // Driver: inputs on the falling edge, outputs checked 1ns after the rising edge.
  task automatic apply(input vec_t v);
    logic [31:0] exp_pc;
    @(negedge clk);
    reset         = v.rst;
    clk_enable    = v.en;
    branch_cond   = v.bc;
    jump_imm      = v.ji;
    jump_reg      = v.jr;
    branch_offset = v.off;
    jump_index    = v.idx;
    reg_target    = v.rt;
    exp_q.push_back(v.exp_pc);
    @(posedge clk);
    #1;
    exp_pc = exp_q.pop_front();
    chk({v.name, ".pc"}, pc, exp_pc);
    chk({v.name, ".pc_plus8"}, pc_plus8, exp_pc + 32'd8);
    chk({v.name, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, v.exp_ds});
    chk({v.name, ".active"}, {31'd0, active}, {31'd0, v.exp_act});
    chk({v.name, ".addr_fault"}, {31'd0, addr_fault}, {31'd0, v.exp_flt});
  endtask

  task automatic step(input logic rst, input logic en, input logic bc, input logic ji,
                      input logic jr, input logic [15:0] off, input logic [25:0] idx,
                      input logic [31:0] rt, input logic [31:0] epc, input logic eds,
                      input logic eact, input logic eflt, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.bc = bc; v.ji = ji; v.jr = jr;
    v.off = off; v.idx = idx; v.rt = rt;
    v.exp_pc = epc; v.exp_ds = eds; v.exp_act = eact; v.exp_flt = eflt;
    v.name = name;
    apply(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; clk_enable = 1'b0; branch_cond = 1'b0; jump_imm = 1'b0;
    jump_reg = 1'b0; branch_offset = '0; jump_index = '0; reg_target = '0;

    //   rst en bc ji jr off       idx       rt             exp_pc         ds act flt
    add(1, 0, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0000, 0, 1, 0, "reset");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0004, 0, 1, 0, "seq1");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0008, 0, 1, 0, "seq2");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_000C, 0, 1, 0, "seq3");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0010, 0, 1, 0, "seq4");
    add(0, 1, 1, 0, 0, 16'hFFFC, 26'h0,    32'h0,         32'hBFC0_0014, 1, 1, 0, "bback_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0004, 0, 1, 0, "bback_tgt");
    for (int i = 0; i < 7; i++) begin
      add(0, 1, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0008 + 32'(i) * 32'd4, 0, 1, 0, "walk");
    end
    add(0, 1, 0, 1, 1, 16'h0000, 26'h100,  32'h0,         32'hBFC0_0024, 1, 1, 0, "halt_slot");
    add(0, 1, 1, 0, 0, 16'h0010, 26'h0,    32'h0,         32'h0000_0000, 0, 0, 0, "halt_tgt");
    add(0, 1, 0, 1, 0, 16'h0000, 26'h40,   32'h0,         32'h0000_0000, 0, 0, 0, "halt_ji");
    add(0, 1, 0, 0, 1, 16'h0000, 26'h0,    32'h0000_1003, 32'h0000_0000, 0, 0, 0, "halt_jr");
    add(0, 1, 1, 0, 0, 16'h0004, 26'h0,    32'h0,         32'h0000_0000, 0, 0, 0, "halt_bc");
    add(1, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0000, 0, 1, 0, "halt_reset");
    add(0, 1, 0, 1, 0, 16'h0000, 26'h40,   32'h0,         32'hBFC0_0004, 1, 1, 0, "j_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hB000_0100, 0, 1, 0, "j_tgt");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hB000_0104, 0, 1, 0, "j_next");
    add(0, 1, 0, 0, 1, 16'h0000, 26'h0,    32'h0000_1002, 32'hB000_0108, 1, 1, 1, "jr_mis_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'h0000_1002, 0, 1, 1, "jr_mis_tgt");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'h0000_1006, 0, 1, 1, "flt_sticky");
    add(1, 0, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hBFC0_0000, 0, 1, 0, "flt_reset");
    add(0, 1, 0, 0, 1, 16'h0000, 26'h0,    32'hFFFF_FFF8, 32'hBFC0_0004, 1, 1, 0, "jr_hi_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'hFFFF_FFF8, 0, 1, 0, "jr_hi_tgt");
    add(0, 1, 1, 0, 0, 16'h0002, 26'h0,    32'h0,         32'hFFFF_FFFC, 1, 1, 0, "bwrap_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'h0000_0004, 0, 1, 0, "bwrap_tgt");
    add(0, 1, 1, 1, 0, 16'h0100, 26'h10,   32'h0,         32'h0000_0008, 1, 1, 0, "prio_slot");
    add(0, 1, 0, 0, 0, 16'h0000, 26'h0,    32'h0,         32'h0000_0040, 0, 1, 0, "prio_tgt");

    foreach (vecs[i]) apply(vecs[i]);

    // Stall inside the delay slot, with a branch presented in the slot.
    step(1, 1, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1, 0, "st_reset");
    step(0, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1, 0, "st_req");
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 16'h0020, 26'h0, 32'h0, 32'hBFC0_0004, 1, 1, 0, "st_frozen");
    end
    step(0, 1, 1, 0, 0, 16'h0020, 26'h0, 32'h0, 32'hBFC0_0044, 0, 1, 0, "st_tgt");
    step(0, 1, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0048, 0, 1, 0, "st_slot_br_dropped");
    step(0, 0, 0, 1, 1, 16'h0000, 26'h3, 32'h3, 32'hBFC0_0048, 0, 1, 0, "st_norm_frozen");
    step(0, 1, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_004C, 0, 1, 0, "st_norm_nocap");

    // Reset while a target is pending in the delay slot.
    step(0, 1, 0, 0, 1, 16'h0000, 26'h0, 32'hBFC0_0100, 32'hBFC0_0050, 1, 1, 0, "rd_slot");
    step(1, 0, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0000, 0, 1, 0, "rd_reset");
    step(0, 1, 0, 0, 0, 16'h0000, 26'h0, 32'h0, 32'hBFC0_0004, 0, 1, 0, "rd_seq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_delay_sequencer.md
PC_DELAY_SEQUENCER -- requirements
Module: pc_delay_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC0_0000, PC value loaded on reset.
REQ-002 SHALL have parameter HALT_ADDR, default 32'h0000_0000; a transfer to this address halts the CPU.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 clk_enable  in  1  global advance enable; low freezes all state.
REQ-006 branch_cond  in  1  current instruction is a taken conditional branch.
REQ-007 jump_imm  in  1  current instruction is J/JAL.
REQ-008 jump_reg  in  1  current instruction is JR/JALR.
REQ-009 branch_offset  in  16  signed word offset of the branch immediate.
REQ-010 jump_index  in  26  J-type index field.
REQ-011 reg_target  in  32  register-file value for JR/JALR.
REQ-012 pc  out  32  address of the instruction currently executing.
REQ-013 pc_plus8  out  32  link address pc+8 for JAL/JALR/BxxAL.
REQ-014 in_delay_slot  out  1  high while the current instruction is in a delay slot.
REQ-015 active  out  1  high until the halt transfer completes.
REQ-016 addr_fault  out  1  sticky flag: a misaligned JR/JALR target was accepted.

Function
REQ-017 The FSM SHALL have states NORMAL, DELAY and HALTED; in_delay_slot=1 only in DELAY; active=0 only in HALTED.
REQ-018 The branch target SHALL be pc+4+(sign_extend(branch_offset)<<2), mod 2^32, so it wraps past 32'hFFFF_FFFC.
REQ-019 The jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-020 The register target SHALL be reg_target unmodified.
REQ-021 Multiple requests SHALL be resolved by priority jump_reg > jump_imm > branch_cond.
REQ-022 In NORMAL with clk_enable=1 and no request: pc <= pc+4, state stays NORMAL.
REQ-023 In NORMAL with clk_enable=1 and any request: pc <= pc+4, the selected target SHALL be latched into an internal held_target register, and state <= DELAY.
REQ-024 In DELAY with clk_enable=1: pc <= held_target; state <= HALTED if held_target==HALT_ADDR, else NORMAL.
REQ-025 All transfer requests SHALL be ignored in DELAY; a branch in a delay slot has no effect.
REQ-026 In HALTED: pc holds HALT_ADDR; all inputs except reset are ignored; the FSM stays in HALTED until reset.
REQ-027 With clk_enable=0: pc, state, held_target and addr_fault SHALL hold; requests presented that cycle are not captured.
REQ-028 When a jump_reg request is accepted with reg_target[1:0]!=0, addr_fault SHALL set; the target is still latched unmodified.
REQ-029 addr_fault SHALL clear only on reset.
REQ-030 pc_plus8 SHALL equal pc+8 mod 2^32, combinationally, in every state.
REQ-031 Transfer latency: the target instruction SHALL appear on pc exactly two enabled cycles after the request cycle; stalled cycles are not counted.

Reset
REQ-032 On reset (clk_enable ignored) the block SHALL set pc=RESET_VECTOR, state=NORMAL, held_target=0, addr_fault=0, in_delay_slot=0 and active=1.
REQ-033 Reset in DELAY or HALTED SHALL abandon the pending target; the next enabled cycle advances sequentially from RESET_VECTOR.

Structure
REQ-034 Package mips_pc_pkg SHALL hold RESET_VECTOR_DEFAULT, HALT_ADDR_DEFAULT and the FSM state enum type.
REQ-035 Target selection and arithmetic SHALL be one combinational sub-module, pc_target_calc; the FSM and registers SHALL be in pc_delay_sequencer.

Verification
REQ-036 Reset, then 3 enabled cycles with no request -> pc sequence BFC00000, BFC00004, BFC00008, BFC0000C; active=1.
REQ-037 pc=BFC00010, branch_cond=1, branch_offset=16'hFFFC -> next pc BFC00014 with in_delay_slot=1, then pc BFC00004 with in_delay_slot=0.
REQ-038 pc=BFC00020, jump_reg=1, jump_imm=1, reg_target=0 -> pc BFC00024 then 00000000; active=0 afterwards; pc holds 0 under further requests.
REQ-039 Request accepted, then clk_enable=0 for 3 cycles in DELAY, and branch_cond=1 asserted in DELAY -> pc and in_delay_slot frozen; the original target is taken and the second branch is ignored.
REQ-040 jump_reg with reg_target=32'h0000_1002 -> addr_fault=1 and pc reaches 00001002; addr_fault stays 1 until reset, then 0.
REQ-041 Reset asserted in DELAY with held_target=BFC00100 -> pc=BFC00000, in_delay_slot=0; the next enabled cycle gives pc BFC00004, not BFC00100.
